// File: rtl/udt_axis_gate.sv
// Per-channel AXIS ready gate driven by UDT socket state; a CLOSE drains the open packet to tlast.
// Optional statistics counters are enabled with the UDT_GATE_STATS_EN macro.
module udt_axis_gate #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned STATE_W = 32,
    parameter logic [STATE_W-1:0] CONNECT = STATE_W'(32'h0000_0001),
    parameter logic [STATE_W-1:0] CLOSE = STATE_W'(32'h0000_0002),
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       core_clk,
    input  logic                       core_rst,
    input  logic [STATE_W-1:0]         udt_state_i,
    input  logic [CH_W-1:0]            state_ch_i,
    input  logic                       state_valid_i,
    input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata_i,
    input  logic [NUM_CH-1:0]          s_axis_tvalid_i,
    input  logic [NUM_CH-1:0]          s_axis_tlast_i,
    output logic [NUM_CH-1:0]          s_axis_tready_o,
    output logic [NUM_CH*DATA_W-1:0]   m_axis_tdata_o,
    output logic [NUM_CH-1:0]          m_axis_tvalid_o,
    output logic [NUM_CH-1:0]          m_axis_tlast_o,
    input  logic [NUM_CH-1:0]          m_axis_tready_i,
    output logic [NUM_CH-1:0]          ready_o,
    output logic [NUM_CH-1:0]          draining_o
`ifdef UDT_GATE_STATS_EN
    ,
    output logic [NUM_CH*16-1:0]       pkt_cnt_o,
    output logic [NUM_CH*16-1:0]       blocked_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_CLOSED = 2'd0,
        ST_OPEN   = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [NUM_CH-1:0] in_pkt_q;
    logic [NUM_CH-1:0] in_pkt_d;
    logic [NUM_CH-1:0] gate;
    logic [NUM_CH-1:0] hs;
    logic [NUM_CH-1:0] last_hs;
    logic [NUM_CH-1:0] cmd_connect;
    logic [NUM_CH-1:0] cmd_close;
    logic              cmd_valid;
    logic              code_connect;
    logic              code_close;

    // Commands to a channel index beyond NUM_CH are dropped.
    assign cmd_valid    = state_valid_i && (32'(state_ch_i) < NUM_CH);
    assign code_connect = (udt_state_i == CONNECT);
    assign code_close   = (udt_state_i == CLOSE);

    // State decode and per-channel command steering.
    always_comb begin : decode
        gate        = '0;
        ready_o     = '0;
        draining_o  = '0;
        cmd_connect = '0;
        cmd_close   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            gate[c]        = (state_q[c] != ST_CLOSED);
            ready_o[c]     = (state_q[c] == ST_OPEN);
            draining_o[c]  = (state_q[c] == ST_DRAIN);
            cmd_connect[c] = cmd_valid && code_connect && (state_ch_i == CH_W'(c));
            cmd_close[c]   = cmd_valid && code_close && (state_ch_i == CH_W'(c));
        end
    end

    // Zero-latency data path; only valid/ready are gated.
    assign m_axis_tdata_o  = s_axis_tdata_i;
    assign m_axis_tlast_o  = s_axis_tlast_i;
    assign m_axis_tvalid_o = s_axis_tvalid_i & gate;
    assign s_axis_tready_o = m_axis_tready_i & gate;
    assign hs              = s_axis_tvalid_i & m_axis_tready_i & gate;
    assign last_hs         = hs & s_axis_tlast_i;

    // Next-state: a reconnect while draining wins over the closing tlast.
    always_comb begin : fsm_next
        in_pkt_d = in_pkt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                ST_CLOSED: if (cmd_connect[c]) state_d[c] = ST_OPEN;
                ST_OPEN: begin
                    if (cmd_close[c])
                        state_d[c] = (in_pkt_q[c] && !last_hs[c]) ? ST_DRAIN : ST_CLOSED;
                end
                ST_DRAIN: begin
                    if (cmd_connect[c])  state_d[c] = ST_OPEN;
                    else if (last_hs[c]) state_d[c] = ST_CLOSED;
                end
                default: state_d[c] = ST_CLOSED;
            endcase
            if (hs[c]) in_pkt_d[c] = !s_axis_tlast_i[c];
        end
    end

    always_ff @(posedge core_clk) begin : fsm_reg
        if (core_rst) begin
            for (int c = 0; c < NUM_CH; c++) state_q[c] <= ST_CLOSED;
            in_pkt_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) state_q[c] <= state_d[c];
            in_pkt_q <= in_pkt_d;
        end
    end

`ifdef UDT_GATE_STATS_EN
    logic [15:0] pkt_cnt_q     [NUM_CH];
    logic [15:0] blocked_cnt_q [NUM_CH];

    // Saturating per-channel packet and blocked-cycle counters.
    always_ff @(posedge core_clk) begin : stats_reg
        for (int c = 0; c < NUM_CH; c++) begin
            if (core_rst) begin
                pkt_cnt_q[c]     <= 16'd0;
                blocked_cnt_q[c] <= 16'd0;
            end else begin
                if (last_hs[c] && (pkt_cnt_q[c] != 16'hFFFF))
                    pkt_cnt_q[c] <= pkt_cnt_q[c] + 16'd1;
                if (s_axis_tvalid_i[c] && !gate[c] && (blocked_cnt_q[c] != 16'hFFFF))
                    blocked_cnt_q[c] <= blocked_cnt_q[c] + 16'd1;
            end
        end
    end

    always_comb begin : stats_out
        pkt_cnt_o     = '0;
        blocked_cnt_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pkt_cnt_o[c*16 +: 16]     = pkt_cnt_q[c];
            blocked_cnt_o[c*16 +: 16] = blocked_cnt_q[c];
        end
    end
`endif

endmodule
